parity_checker: RTL and testbench

Registered even/odd parity checker for a DATA_W-bit word plus its received parity bit. Each valid beat produces a one-cycle-latency error flag, the locally generated parity bit, a sticky error flag and a saturating error counter. Sits at the receive side of a parity-protected link or storage read path, downstream of the data source and upstream of error reporting logic.

---
 rtl/parity_checker_pkg.sv | 8 +
 rtl/parity_checker_parity_gen.sv | 19 +
 rtl/parity_checker.sv | 96 +++++++++
 tb/tb_parity_checker.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_checker_pkg.sv
// Shared definitions for the parity checker slice: parity mode encodings
// used on the even_odd select of both the checker and the generator.
package parity_checker_pkg;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_checker_parity_gen.sv
// Combinational parity generator. Produces the parity bit a sender would
// attach to data under the selected mode, so it can be reused on the
// transmit side as well as inside the receive-side checker.
module parity_gen
   import parity_checker_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] data,
   input  logic              even_odd,
   output logic              gen
);

   // Even mode yields the XOR of all data bits; odd mode inverts it.
   always_comb begin
      gen = (^data) ^ (even_odd == PAR_ODD);
   end

endmodule

// File: rtl/parity_checker.sv
// Registered even/odd parity checker. Each valid beat reports, one cycle
// later, whether the received parity bit matched the locally generated one,
// along with a sticky error flag and a saturating error counter.
module parity_checker
   import parity_checker_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] data,
   input  logic              parity_bit,
   input  logic              even_odd,
   input  logic              clr,
   output logic              out_valid,
   output logic              error,
   output logic              gen_parity,
   output logic              err_sticky,
   output logic [CNT_W-1:0]  err_count
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic             gen;
   logic             mismatch;
   logic             outValid_d,  outValid_q;
   logic             error_d,     error_q;
   logic             genParity_d, genParity_q;
   logic             errSticky_d, errSticky_q;
   logic [CNT_W-1:0] errCount_d,  errCount_q;

   parity_gen #(
      .DATA_W (DATA_W)
   ) u_parity_gen (
      .data     (data),
      .even_odd (even_odd),
      .gen      (gen)
   );

   // A beat is in error when the received parity disagrees with the generated one.
   always_comb begin
      mismatch = parity_bit ^ gen;
   end

   // Next-state for the per-beat report; gen_parity keeps its value across idle cycles.
   always_comb begin
      outValid_d  = in_valid;
      error_d     = 1'b0;
      genParity_d = genParity_q;
      if (in_valid) begin
         error_d     = mismatch;
         genParity_d = gen;
      end
   end

   // Next-state for the error history; clr beats a coincident error beat.
   always_comb begin
      errSticky_d = errSticky_q;
      errCount_d  = errCount_q;
      if (clr) begin
         errSticky_d = 1'b0;
         errCount_d  = '0;
      end else if (in_valid && mismatch) begin
         errSticky_d = 1'b1;
         if (errCount_q != CntMax) begin
            errCount_d = errCount_q + 1'b1;
         end
      end
   end

   // All outputs come straight from these flops; rst overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         outValid_q  <= 1'b0;
         error_q     <= 1'b0;
         genParity_q <= 1'b0;
         errSticky_q <= 1'b0;
         errCount_q  <= '0;
      end else begin
         outValid_q  <= outValid_d;
         error_q     <= error_d;
         genParity_q <= genParity_d;
         errSticky_q <= errSticky_d;
         errCount_q  <= errCount_d;
      end
   end

   assign out_valid  = outValid_q;
   assign error      = error_q;
   assign gen_parity = genParity_q;
   assign err_sticky = errSticky_q;
   assign err_count  = errCount_q;

endmodule

// File: tb/tb_parity_checker.sv
// Testbench for parity_checker. Two instances share the same stimulus: one
// with an 8-bit counter and one with a 2-bit counter to reach saturation.
// Expected values come from a reference model that counts ones in the data.
module tb_parity_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] data = 8'h00;
   logic       parity_bit = 1'b0;
   logic       even_odd = 1'b0;
   logic       clr = 1'b0;

   logic       out_valid, error, gen_parity, err_sticky;
   logic [7:0] err_count;
   logic       satOutValid, satError, satGenParity, satErrSticky;
   logic [1:0] satErrCount;

   int nCompared   = 0;
   int nMismatched = 0;

   // Reference model state
   logic expOutValid = 1'b0;
   logic expError    = 1'b0;
   logic expGen      = 1'b0;
   logic expSticky   = 1'b0;
   int   expCount    = 0;
   int   expCountSat = 0;

   parity_checker #(.DATA_W(8), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .data       (data),
      .parity_bit (parity_bit),
      .even_odd   (even_odd),
      .clr        (clr),
      .out_valid  (out_valid),
      .error      (error),
      .gen_parity (gen_parity),
      .err_sticky (err_sticky),
      .err_count  (err_count)
   );

   parity_checker #(.DATA_W(8), .CNT_W(2)) dutSat (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .data       (data),
      .parity_bit (parity_bit),
      .even_odd   (even_odd),
      .clr        (clr),
      .out_valid  (satOutValid),
      .error      (satError),
      .gen_parity (satGenParity),
      .err_sticky (satErrSticky),
      .err_count  (satErrCount)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, advance the model across the clock edge,
   // then leave the caller 1 time unit past the edge to sample outputs.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic p,
                                input logic m, input logic c, input logic r);
      int  ones;
      logic expectedParity;
      logic isError;
      @(negedge clk);
      in_valid   = v;
      data       = d;
      parity_bit = p;
      even_odd   = m;
      clr        = c;
      rst        = r;
      @(posedge clk);
      ones = $countones(d);
      if (m == 1'b0) expectedParity = (ones % 2 == 1);
      else           expectedParity = (ones % 2 == 0);
      isError = v && (p != expectedParity);
      if (r) begin
         expOutValid = 1'b0;
         expError    = 1'b0;
         expGen      = 1'b0;
         expSticky   = 1'b0;
         expCount    = 0;
         expCountSat = 0;
      end else begin
         expOutValid = v;
         expError    = isError;
         if (v) expGen = expectedParity;
         if (c) begin
            expSticky   = 1'b0;
            expCount    = 0;
            expCountSat = 0;
         end else if (isError) begin
            expSticky   = 1'b1;
            expCount    = (expCount + 1 > 255) ? 255 : expCount + 1;
            expCountSat = (expCountSat + 1 > 3) ? 3 : expCountSat + 1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      applyStimulus(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      nCompared++;
      if ({out_valid, error, gen_parity, err_sticky, err_count} !== 12'h000) begin
         nMismatched++;
         $display("[TB] FAIL reset_outputs: got ov=%b err=%b gen=%b st=%b cnt=%0d, want all 0",
                  out_valid, error, gen_parity, err_sticky, err_count);
      end
      nCompared++;
      if ({satOutValid, satError, satGenParity, satErrSticky, satErrCount} !== 6'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_sat_outputs: got cnt=%0d st=%b, want all 0", satErrCount, satErrSticky);
      end
   endtask

   task automatic test_even();
      applyStimulus(1'b1, 8'b10101010, 1'b0, 1'b0, 1'b0, 1'b0);
      nCompared++;
      if ({out_valid, error, gen_parity, err_count} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
         nMismatched++;
         $display("[TB] FAIL even_ok: got ov=%b err=%b gen=%b cnt=%0d, want 1 0 0 0",
                  out_valid, error, gen_parity, err_count);
      end
      applyStimulus(1'b1, 8'b10101010, 1'b1, 1'b0, 1'b0, 1'b0);
      nCompared++;
      if ({error, err_sticky, err_count} !== {1'b1, 1'b1, 8'd1}) begin
         nMismatched++;
         $display("[TB] FAIL even_bad: got err=%b st=%b cnt=%0d, want 1 1 1", error, err_sticky, err_count);
      end
   endtask

   task automatic test_odd();
      applyStimulus(1'b1, 8'b00000111, 1'b0, 1'b1, 1'b0, 1'b0);
      nCompared++;
      if ({out_valid, error, gen_parity} !== 3'b100) begin
         nMismatched++;
         $display("[TB] FAIL odd_ok: got ov=%b err=%b gen=%b, want 1 0 0", out_valid, error, gen_parity);
      end
      applyStimulus(1'b1, 8'b00000111, 1'b1, 1'b1, 1'b0, 1'b0);
      nCompared++;
      if (error !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL odd_bad: got err=%b, want 1", error);
      end
      applyStimulus(1'b1, 8'b00000011, 1'b1, 1'b1, 1'b0, 1'b0);
      nCompared++;
      if ({error, gen_parity} !== 2'b01) begin
         nMismatched++;
         $display("[TB] FAIL odd_even_ones: got err=%b gen=%b, want 0 1", error, gen_parity);
      end
   endtask

   task automatic test_saturation();
      logic [1:0] satSeq [5];
      satSeq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'b10101010, 1'b1, 1'b0, 1'b0, 1'b0);
         nCompared++;
         if (satErrCount !== satSeq[i]) begin
            nMismatched++;
            $display("[TB] FAIL sat_count[%0d]: got %0d, want %0d", i, satErrCount, satSeq[i]);
         end
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      nCompared++;
      if ({satErrCount, satErrSticky, err_count, err_sticky} !== {2'd0, 1'b0, 8'd0, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL sat_clr: got cnt=%0d st=%b cnt8=%0d st8=%b, want 0", satErrCount, satErrSticky,
                  err_count, err_sticky);
      end
      applyStimulus(1'b1, 8'b10101010, 1'b1, 1'b0, 1'b1, 1'b0);
      nCompared++;
      if ({satErrCount, satErrSticky, satError, satOutValid} !== {2'd0, 1'b0, 1'b1, 1'b1}) begin
         nMismatched++;
         $display("[TB] FAIL clr_with_error: got cnt=%0d st=%b err=%b ov=%b, want 0 0 1 1",
                  satErrCount, satErrSticky, satError, satOutValid);
      end
   endtask

   task automatic test_idle();
      applyStimulus(1'b1, 8'b10101010, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'b00000001, 1'b0, 1'b0, 1'b0, 1'b0);
      nCompared++;
      if ({out_valid, error, gen_parity, err_count} !== {1'b0, 1'b0, 1'b0, 8'd1}) begin
         nMismatched++;
         $display("[TB] FAIL idle: got ov=%b err=%b gen=%b cnt=%0d, want 0 0 0 1",
                  out_valid, error, gen_parity, err_count);
      end
      applyStimulus(1'b1, 8'b00000001, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'b00000000, 1'b1, 1'b0, 1'b0, 1'b0);
      nCompared++;
      if ({out_valid, error, gen_parity} !== 3'b001) begin
         nMismatched++;
         $display("[TB] FAIL idle_gen_hold: got ov=%b err=%b gen=%b, want 0 0 1", out_valid, error, gen_parity);
      end
   endtask

   task automatic test_reset_midstream();
      applyStimulus(1'b1, 8'b10101010, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'b00000001, 1'b0, 1'b0, 1'b0, 1'b1);
      nCompared++;
      if ({out_valid, error, gen_parity, err_sticky, err_count} !== 12'h000) begin
         nMismatched++;
         $display("[TB] FAIL reset_midstream: got ov=%b err=%b gen=%b st=%b cnt=%0d, want all 0",
                  out_valid, error, gen_parity, err_sticky, err_count);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(1'($urandom_range(3) != 0), 8'($urandom()), 1'($urandom()), 1'($urandom()),
                       1'($urandom_range(39) == 0), 1'b0);
         nCompared++;
         if ({out_valid, error, gen_parity, err_sticky} !== {expOutValid, expError, expGen, expSticky}) begin
            nMismatched++;
            $display("[TB] FAIL rand_flags[%0d]: got ov=%b err=%b gen=%b st=%b, want %b %b %b %b", i,
                     out_valid, error, gen_parity, err_sticky, expOutValid, expError, expGen, expSticky);
         end
         nCompared++;
         if (err_count !== 8'(expCount) || satErrCount !== 2'(expCountSat)) begin
            nMismatched++;
            $display("[TB] FAIL rand_count[%0d]: got %0d/%0d, want %0d/%0d", i,
                     err_count, satErrCount, expCount, expCountSat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_even();
      test_odd();
      test_saturation();
      test_idle();
      test_reset_midstream();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
